// File: rtl/seg_pattern_rx.sv
// seg_pattern_rx: recovers per-digit hex nibbles from sampled active-low 7-seg lines; define SEG_RX_ERRCNT_EN to build the err_cnt counter
module seg_pattern_rx #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sample_en,
   input  logic [6:0]            seg_in,
   input  logic [DIGITS-1:0]     dig_sel,
   output logic [4*DIGITS-1:0]   nibble_out,
   output logic [DIGITS-1:0]     blank_out,
   output logic                  valid,
   output logic [2:0]            valid_digit,
   output logic                  err,
   output logic [2:0]            err_digit,
   output logic [7:0]            err_cnt
);
   localparam logic [3:0] SC = 4'(STABLE_CYCLES);
   logic [DIGITS+6:0]   prev_q, s;
   logic [3:0]          run_q, run_d;
   logic [4*DIGITS-1:0] nib_q;
   logic [DIGITS-1:0]   blank_q;
   logic                valid_q, err_q, commit, dec_ok, dec_blank, err_set;
   logic [2:0]          vdig_q, edig_q, idx;
   logic [3:0]          dec_nib;
   // map the active-low segment pattern to a nibble, a blank flag or illegal
   always_comb begin
      dec_nib   = 4'h0;
      dec_ok    = 1'b1;
      dec_blank = 1'b0;
      case (seg_in)
         7'b1000000: dec_nib = 4'h0;
         7'b1111001: dec_nib = 4'h1;
         7'b0100100: dec_nib = 4'h2;
         7'b0110000: dec_nib = 4'h3;
         7'b0011001: dec_nib = 4'h4;
         7'b0010010: dec_nib = 4'h5;
         7'b0000010: dec_nib = 4'h6;
         7'b1111000: dec_nib = 4'h7;
         7'b0000000: dec_nib = 4'h8;
         7'b0010000: dec_nib = 4'h9;
         7'b0001000: dec_nib = 4'hA;
         7'b0000011: dec_nib = 4'hB;
         7'b1000110: dec_nib = 4'hC;
         7'b0100001: dec_nib = 4'hD;
         7'b0000110: dec_nib = 4'hE;
         7'b0001110: dec_nib = 4'hF;
         7'b1111111: dec_blank = 1'b1;
         default:    dec_ok = 1'b0;
      endcase
   end
   // stability run tracking; commit only on the sample that reaches STABLE_CYCLES
   always_comb begin
      s       = {dig_sel, seg_in};
      run_d   = !$onehot(dig_sel) ? 4'd0 : (s != prev_q) ? 4'd1 : (run_q == SC) ? SC : run_q + 4'd1;
      commit  = sample_en && run_d == SC && run_q != SC;
      err_set = commit && !dec_ok;
      idx     = 3'd0;
      for (int i = 0; i < DIGITS; i++) if (dig_sel[i]) idx = 3'(i);
   end
   // sample registers, per-digit storage and the one-cycle result pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q  <= '0;
         run_q   <= 4'd0;
         nib_q   <= '0;
         blank_q <= '1;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         vdig_q  <= 3'd0;
         edig_q  <= 3'd0;
      end else begin
         valid_q <= commit && dec_ok;
         err_q   <= err_set;
         if (sample_en) begin
            prev_q <= s;
            run_q  <= run_d;
         end
         if (commit && dec_ok) vdig_q <= idx;
         if (err_set) edig_q <= idx;
         for (int i = 0; i < DIGITS; i++) begin
            if (commit && dig_sel[i] && dec_ok) begin
               blank_q[i] <= dec_blank;
               if (!dec_blank) nib_q[4*i +: 4] <= dec_nib;
            end
         end
      end
   end
`ifdef SEG_RX_ERRCNT_EN
   logic [7:0] cnt_q;
   // saturating count of illegal stable patterns, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= 8'd0;
      else if (err_set && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
   end
   assign err_cnt = cnt_q;
`else
   assign err_cnt = 8'd0;
`endif
   assign nibble_out  = nib_q;
   assign blank_out   = blank_q;
   assign valid       = valid_q;
   assign valid_digit = vdig_q;
   assign err         = err_q;
   assign err_digit   = edig_q;
endmodule

// File: tb/tb_seg_pattern_rx.sv
// tb_seg_pattern_rx: directed self-checking bench for seg_pattern_rx
module tb_seg_pattern_rx;
   logic        clk = 1'b0;
   logic        rst, sample_en;
   logic [6:0]  seg_in;
   logic [3:0]  dig_sel;
   logic [15:0] nibble_out;
   logic [3:0]  blank_out;
   logic        valid, err;
   logic [2:0]  valid_digit, err_digit;
   logic [7:0]  err_cnt;
   int          nvec = 0;
   int          nerr = 0;
   seg_pattern_rx #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .sample_en(sample_en), .seg_in(seg_in), .dig_sel(dig_sel),
      .nibble_out(nibble_out), .blank_out(blank_out), .valid(valid), .valid_digit(valid_digit),
      .err(err), .err_digit(err_digit), .err_cnt(err_cnt)
   );
   always #5 clk = ~clk;
   task automatic tick(input logic en, input logic [3:0] sel, input logic [6:0] seg);
      sample_en = en;
      dig_sel   = sel;
      seg_in    = seg;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, 32'(valid), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask
   initial begin
      logic [7:0] cnt_exp;
`ifdef SEG_RX_ERRCNT_EN
      cnt_exp = 8'd1;
`else
      cnt_exp = 8'd0;
`endif
      rst = 1'b1;
      tick(1'b0, 4'b0000, 7'b0000000);
      tick(1'b0, 4'b0000, 7'b0000000);
      chk("rst_nib", 32'(nibble_out), 32'h0000);
      chk("rst_blank", 32'(blank_out), 32'hF);
      chk("rst_vdig", 32'(valid_digit), 32'd0);
      chk("rst_edig", 32'(err_digit), 32'd0);
      chk("rst_cnt", 32'(err_cnt), 32'd0);
      chk_idle("rst");
      rst = 1'b0;
      // digit 0 shows 3 for four samples
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 4'b0001, 7'b0110000);
         chk_idle("t1_pre");
      end
      tick(1'b1, 4'b0001, 7'b0110000);
      chk("t1_valid", 32'(valid), 32'd1);
      chk("t1_vdig", 32'(valid_digit), 32'd0);
      chk("t1_nib", 32'(nibble_out), 32'h0003);
      chk("t1_blank", 32'(blank_out), 32'hE);
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 4'b0001, 7'b0110000);
         chk_idle("t1_hold");
      end
      // restart a run of 3, then change to 5 before it can commit
      tick(1'b1, 4'b0000, 7'b0110000);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 4'b0001, 7'b0110000);
         chk_idle("t2_three");
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 4'b0001, 7'b0010010);
         chk_idle("t2_pre");
      end
      tick(1'b1, 4'b0001, 7'b0010010);
      chk("t2_valid", 32'(valid), 32'd1);
      chk("t2_nib", 32'(nibble_out), 32'h0005);
      // gapped samples on digit 2 still commit F
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 4'b0100, 7'b0001110);
         chk_idle("t3_on");
         tick(1'b0, 4'b0100, 7'b0001110);
         chk_idle("t3_gap");
      end
      tick(1'b1, 4'b0100, 7'b0001110);
      chk("t3_valid", 32'(valid), 32'd1);
      chk("t3_vdig", 32'(valid_digit), 32'd2);
      chk("t3_nib", 32'(nibble_out), 32'h0F05);
      chk("t3_blank", 32'(blank_out), 32'hA);
      tick(1'b0, 4'b0100, 7'b0001110);
      chk_idle("t3_after");
      // illegal stable pattern on digit 1
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 4'b0010, 7'b1010101);
         chk_idle("t4_pre");
      end
      tick(1'b1, 4'b0010, 7'b1010101);
      chk("t4_err", 32'(err), 32'd1);
      chk("t4_valid", 32'(valid), 32'd0);
      chk("t4_edig", 32'(err_digit), 32'd1);
      chk("t4_nib", 32'(nibble_out), 32'h0F05);
      chk("t4_blank", 32'(blank_out), 32'hA);
      chk("t4_cnt", 32'(err_cnt), 32'(cnt_exp));
      tick(1'b1, 4'b0010, 7'b1010101);
      chk_idle("t4_after");
      // non-one-hot select never commits
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, 4'b0011, 7'b1000000);
         chk_idle("t5_multi");
      end
      // digit 3: commit 0 then blank it
      for (int i = 0; i < 4; i++) tick(1'b1, 4'b1000, 7'b1000000);
      chk("t5_zero_valid", 32'(valid), 32'd1);
      chk("t5_zero_blank", 32'(blank_out), 32'h2);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 4'b1000, 7'b1111111);
         chk_idle("t5_bpre");
      end
      tick(1'b1, 4'b1000, 7'b1111111);
      chk("t5_bvalid", 32'(valid), 32'd1);
      chk("t5_bvdig", 32'(valid_digit), 32'd3);
      chk("t5_blank", 32'(blank_out), 32'hA);
      chk("t5_nib", 32'(nibble_out), 32'h0F05);
      // digit 2 = 7, then reset in the middle of a run on digit 0
      for (int i = 0; i < 4; i++) tick(1'b1, 4'b0100, 7'b1111000);
      chk("t6_nib7", 32'(nibble_out), 32'h0705);
      tick(1'b1, 4'b0001, 7'b0000000);
      tick(1'b1, 4'b0001, 7'b0000000);
      rst = 1'b1;
      tick(1'b1, 4'b0001, 7'b0000000);
      rst = 1'b0;
      chk("t6_rnib", 32'(nibble_out), 32'h0000);
      chk("t6_rblank", 32'(blank_out), 32'hF);
      chk("t6_rcnt", 32'(err_cnt), 32'd0);
      chk_idle("t6_rst");
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 4'b0001, 7'b0000000);
         chk_idle("t6_pre");
      end
      tick(1'b1, 4'b0001, 7'b0000000);
      chk("t6_valid", 32'(valid), 32'd1);
      chk("t6_nib", 32'(nibble_out), 32'h0008);
      chk("t6_blank", 32'(blank_out), 32'hE);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
